// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: load/store handshake with a multi-cycle data memory.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [4:0]  LW_OP   = 5'b01000,
  parameter logic [4:0]  SW_OP   = 5'b00111,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       o_in,
  input  logic [31:0]       b_in,
  input  logic              valid_in,
  input  logic              exception_in,
  output logic [31:0]       instr_out,
  output logic [31:0]       o_out,
  output logic [31:0]       d_out,
  output logic              valid_out,
  output logic              exception_out,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be nonzero");
  end

  state_e      state_q, state_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        is_store_q, is_store_d;
  logic        req;
  logic        timed_out;

  logic [4:0] opcode;
  logic       is_store;
  logic       is_mem;

  assign opcode   = instr_in[31:27];
  assign is_store = (opcode == SW_OP);
  assign is_mem   = valid_in && !exception_in && ((opcode == LW_OP) || is_store);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW   = (CntRaw > 5) ? CntRaw : 5;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  assign timed_out = timeout_q;
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ld_data_d  = ld_data_q;
    is_store_d = is_store_q;
    req        = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle, StWait: begin
        // In StWait the inputs are frozen by the stall, so no re-decode is needed.
        if ((state_q == StWait) || is_mem) begin
          req = 1'b1;
          if (state_q == StIdle) begin
            is_store_d = is_store;
          end
          if (mem_ack) begin
            state_d   = StDone;
            ld_data_d = mem_rdata;
`ifdef MEM_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end else begin
            state_d = StWait;
`ifdef MEM_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(TIMEOUT - 1)) begin
              state_d   = StDone;
              timeout_d = 1'b1;
              cnt_d     = '0;
            end
`endif
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ld_data_q  <= '0;
      is_store_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ld_data_q  <= ld_data_d;
      is_store_q <= is_store_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Gating with reset drops the request asynchronously even though inputs still hold a mem op.
  assign mem_req   = reset && req;
  assign stall     = mem_req;
  assign mem_we    = is_store;
  assign mem_addr  = o_in[ADDR_W-1:0];
  assign mem_wdata = b_in;

  assign instr_out     = instr_in;
  assign o_out         = o_in;
  assign exception_out = exception_in || ((state_q == StDone) && timed_out);
  assign valid_out     = (state_q == StDone) ? 1'b1 : (valid_in && !stall);
  assign d_out         = ((state_q == StDone) && !is_store_q && !timed_out) ? ld_data_q : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage against an array-based memory reference model.
// Timeout scenarios are exercised when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

  localparam logic [4:0] LwOp  = 5'b01000;
  localparam logic [4:0] SwOp  = 5'b00111;
  localparam logic [4:0] AddOp = 5'b00000;
`ifdef MEM_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
  localparam int MaxLat = 6;
`else
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b0;
  localparam int MaxLat = 4;
`endif

  logic        clk, reset;
  logic [31:0] instr_in, o_in, b_in;
  logic        valid_in, exception_in;
  logic [31:0] instr_out, o_out, d_out;
  logic        valid_out, exception_out, stall;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  mem_access_stage #(.ADDR_W(12), .LW_OP(LwOp), .SW_OP(SwOp), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_in     (instr_in),
    .o_in         (o_in),
    .b_in         (b_in),
    .valid_in     (valid_in),
    .exception_in (exception_in),
    .instr_out    (instr_out),
    .o_out        (o_out),
    .d_out        (d_out),
    .valid_out    (valid_out),
    .exception_out(exception_out),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] o;
    logic [31:0] d;
    logic        exc;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference memory (model) and device memory (environment) start identical.
  logic [31:0] ref_mem[16];
  logic [31:0] dev_mem[16];

  // Memory device: acks after cur_lat non-acked request cycles.
  bit          dev_en = 1'b1;
  logic        dev_ack = 1'b0;
  logic        force_ack = 1'b0;
  int          cur_lat = 0;
  int          wait_cnt = 0;
  assign mem_ack = dev_en ? dev_ack : force_ack;

  initial mem_rdata = '0;

  always @(negedge clk) begin
    if (dev_en && reset && mem_req && !dev_ack) begin
      if (wait_cnt == cur_lat) begin
        dev_ack   = 1'b1;
        mem_rdata = dev_mem[mem_addr[3:0]];
        if (mem_we) dev_mem[mem_addr[3:0]] = mem_wdata;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      dev_ack = 1'b0;
      if (!mem_req || !dev_en || !reset) wait_cnt = 0;
    end
  end

  // Expected memory-interface contents for the instruction currently presented.
  bit          mon_en = 1'b1;
  logic        exp_req = 1'b0;
  logic        exp_we = 1'b0;
  logic [11:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;

  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (mem_req) begin
        check("mem_req_legal", 32'(mem_req), 32'(exp_req));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
      if (valid_out && !stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_capture", 32'(valid_out), 32'd0);
        end else begin
          out_t e;
          e = exp_q.pop_front();
          check("instr_out", instr_out, e.instr);
          check("o_out", o_out, e.o);
          check("d_out", d_out, e.d);
          check("exception_out", 32'(exception_out), 32'(e.exc));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] instr, input logic [31:0] o, input logic [31:0] b,
                       input bit v, input bit e, input int lat);
    logic [4:0] op;
    bit         is_mem, timed;
    out_t       x;
    int         stalls, exp_stalls;
    @(posedge clk);
    #1;
    instr_in = instr; o_in = o; b_in = b; valid_in = v; exception_in = e;
    cur_lat  = lat;
    op       = instr[31:27];
    is_mem   = v && !e && (op == LwOp || op == SwOp);
    timed    = is_mem && TO_EN && (lat >= TO);
    x.instr  = instr; x.o = o; x.d = '0; x.exc = e || timed;
    if (is_mem && !timed) begin
      if (op == LwOp) x.d = ref_mem[o[3:0]];
      else ref_mem[o[3:0]] = b;
    end
    if (v) exp_q.push_back(x);
    exp_req = is_mem; exp_we = (op == SwOp); exp_addr = o[11:0]; exp_wdata = b;
    exp_stalls = !is_mem ? 0 : (timed ? TO : lat + 1);
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
  endtask

  initial begin
    logic [31:0] r, ri, ro, rb;
    logic [4:0]  rop;
    int          sel;
    logic [4:0]  others[3];
    others[0] = 5'b00001; others[1] = 5'b10000; others[2] = 5'b11111;

    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      ref_mem[i] = r;
      dev_mem[i] = r;
    end
    ref_mem[0] = 32'hDEAD_BEEF;
    dev_mem[0] = 32'hDEAD_BEEF;

    reset = 1'b0;
    instr_in = '0; o_in = '0; b_in = '0; valid_in = 1'b0; exception_in = 1'b0;
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_d_out", d_out, 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    // Directed cases
    issue({AddOp, 27'h0012345}, 32'h5, 32'h0, 1'b1, 1'b0, 0);
    issue({LwOp, 27'h0000001}, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 0);
    issue({SwOp, 27'h0000002}, 32'h0000_0020, 32'h1234, 1'b1, 1'b0, 3);
    issue({LwOp, 27'h0000003}, 32'h0000_0020, 32'h0, 1'b1, 1'b0, 1);
    issue({SwOp, 27'h0000004}, 32'h0000_0030, 32'hBAD, 1'b1, 1'b1, 0);
    issue({LwOp, 27'h0000005}, 32'h0000_0030, 32'h0, 1'b0, 1'b0, 0);
    issue({LwOp, 27'h0000006}, 32'h0000_0030, 32'h0, 1'b1, 1'b0, 0);
`ifdef MEM_TIMEOUT_EN
    issue({LwOp, 27'h0000007}, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 9);
    issue({LwOp, 27'h0000008}, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 3);
`endif

    // Asynchronous reset in the 2nd WAIT cycle, then a stray ack after release.
    @(posedge clk);
    #1;
    dev_en = 1'b0; force_ack = 1'b0;
    instr_in = {LwOp, 27'h0000009}; o_in = 32'h11; b_in = '0; valid_in = 1'b1;
    exception_in = 1'b0;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 12'h011;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    check("pre_rst_stall", 32'(stall), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    check("async_rst_d_out", d_out, 32'd0);
    instr_in = {AddOp, 27'h000000A}; o_in = 32'h77; exp_req = 1'b0;
    force_ack = 1'b1;
    begin
      out_t x;
      x.instr = instr_in; x.o = o_in; x.d = '0; x.exc = 1'b0;
      exp_q.push_back(x);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("stray_ack_stall", 32'(stall), 32'd0);
    check("stray_ack_mem_req", 32'(mem_req), 32'd0);
    check("stray_ack_d_out", d_out, 32'd0);
    #1;
    valid_in = 1'b0; force_ack = 1'b0; dev_en = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) rop = LwOp;
      else if (sel == 1) rop = SwOp;
      else if (sel == 2) rop = AddOp;
      else rop = others[$urandom_range(0, 2)];
      ri = $urandom(); ro = $urandom(); rb = $urandom();
      issue({rop, ri[26:0]}, ro, rb, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            $urandom_range(0, MaxLat));
    end

    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage pipeline, sitting between the X/M latch and the M/W latch; its outputs feed the M/W latch inputs directly.
- Decodes load and store instructions and runs a request/acknowledge handshake with the data memory, which may take multiple cycles.
- Raises a stall that freezes the PC, F/D, D/X and X/M latches while an access is outstanding.
- Non-memory instructions pass straight through with zero added latency.

Parameters:
- ADDR_W, 12, data-memory word-address width; mem_addr = o_in[ADDR_W-1:0].
- LW_OP, 5'b01000, opcode (instr[31:27]) of a load.
- SW_OP, 5'b00111, opcode of a store.
- TIMEOUT, 16, maximum request cycles before abort (only used with the optional feature).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- instr_in  in  32  instruction from the X/M latch.
- o_in  in  32  ALU result / effective address from the X/M latch.
- b_in  in  32  store data from the X/M latch.
- valid_in  in  1  X/M slot holds a real instruction (0 = bubble).
- exception_in  in  1  exception flag from the X/M latch.
- instr_out  out  32  to the M/W latch.
- o_out  out  32  to the M/W latch.
- d_out  out  32  load data to the M/W latch.
- valid_out  out  1  slot valid to the M/W latch.
- exception_out  out  1  to the M/W latch.
- stall  out  1  1 = hold all upstream latches and hold the M/W latch write enable low.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req = 1.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data; valid in the mem_ack cycle.
- mem_ack  in  1  single-cycle completion strobe.

Behaviour:
- An instruction is a memory op when valid_in = 1, exception_in = 0, and the opcode equals LW_OP or SW_OP.
- A suppressed op (invalid or excepting) never raises mem_req; a store in that slot must never reach memory.
- FSM states:
  - IDLE: non-memory op → outputs are a combinational pass-through, stall = 0, d_out = 0. Memory op → mem_req = 1, stall = 1; go to WAIT, or directly to DONE if mem_ack = 1 in this same cycle.
  - WAIT: mem_req = 1, stall = 1, and mem_addr/mem_we/mem_wdata stay stable (inputs are frozen by the stall). mem_ack = 1 → go to DONE.
  - DONE: lasts exactly 1 cycle. mem_req = 0, stall = 0, valid_out = 1. The M/W latch captures at the end of this cycle; next state is IDLE.
- Load data: on the mem_ack edge, mem_rdata is captured into ld_data. d_out = ld_data in DONE for a load, and 0 for a store.
- Minimum cost of a memory op: 2 cycles (1 stall cycle). Each extra ack wait adds 1 cycle.
- In DONE the same instruction is still on the inputs; it must not re-issue.
- mem_ack outside IDLE-with-memory-op and WAIT is ignored.
- In every state, instr_out = instr_in, o_out = o_in, and exception_out = exception_in (except on timeout).
- valid_out = valid_in, except it is held at 0 while stall = 1.
- Reset (asserted at 0, asynchronous): state = IDLE, ld_data = 0, counter = 0, mem_req = 0, stall = 0.
  - Reset mid-WAIT drops the request immediately; a late mem_ack after release is ignored.
- Outputs during reset are combinational pass-through with d_out = 0.
- Back-to-back memory ops: DONE → IDLE → new request on the following cycle. No cycle is lost beyond the DONE cycle.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A 5-bit-minimum wait counter (sized by $clog2(TIMEOUT+1)) increments on every mem_req cycle without mem_ack.
  - When the count reaches TIMEOUT with no ack: drop mem_req, go to DONE with exception_out = 1 and d_out = 0, then clear the counter.
  - An ack in the same cycle that the count hits TIMEOUT wins, completing normally.
- Undefined: no counter; WAIT holds indefinitely until mem_ack.

Test Plan:
- Pass-through: add (opcode 00000) with o_in = 32'h5 → instr_out/o_out follow the same cycle, stall = 0, mem_req never 1, d_out = 0.
- Zero-wait load: lw, o_in = 32'h0000_0010, mem_ack in the request cycle with mem_rdata = 32'hDEAD_BEEF → mem_addr = 12'h010, mem_we = 0, stall for 1 cycle, DONE cycle d_out = DEADBEEF, valid_out = 1.
- 3-wait store: sw, b_in = 32'h1234, ack after 3 cycles → mem_we = 1, mem_wdata = 1234 stable for 4 request cycles, stall = 1 for 4 cycles, then DONE with d_out = 0.
- Suppression: sw with exception_in = 1, then lw with valid_in = 0 → mem_req stays 0 both times, stall = 0, exception_out = 1 for the first.
- Async reset: assert reset (0) in the 2nd WAIT cycle → mem_req and stall drop without a clock edge; after release with a stray mem_ack, the state stays IDLE and d_out = 0.
- MEM_TIMEOUT_EN, TIMEOUT = 4: lw with no ack → mem_req high for 4 cycles, then DONE with exception_out = 1, d_out = 0; repeat with ack in the 4th cycle → normal completion, exception_out = 0.
